// File: rtl/rtc_bus_reader.sv
// rtc_bus_reader
// ---------------------------------------------------------------------------
// Read-side bus master for the RTC register interface. A single-cycle start
// runs one multiplexed address/data read on the RTC bus. The returned BCD byte
// is captured, converted to 7-bit binary and presented with a one-cycle done
// strobe, ready to feed the load inputs of the input counters.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   start     request one read; sampled only in IDLE
//   addr      RTC register address, latched when start is accepted
//   ad_in     RTC bus read data
//   ad_out    RTC bus address out
//   ad_oe     1 drives ad_out onto the bus
//   a_d       0 = address phase, 1 = data phase
//   cs_n      active-low chip select
//   rd_n      active-low read strobe
//   wr_n      active-low address-latch strobe (no data is ever written)
//   busy      high from start acceptance through the done cycle
//   done      one-cycle pulse; results valid and stable from this cycle on
//   rd_bcd    raw byte captured from the bus
//   rd_bin    binary value of rd_bcd (0 when the byte is not valid BCD)
//   bcd_err   captured byte had a nibble greater than 9
//   dbg_state current FSM state, for observation only
//
// Handshake: start is a request pulse accepted only while busy = 0; there is
// no back-pressure and nothing is queued. Each accepted start produces exactly
// one done pulse, unless reset aborts the read, in which case none is produced.
// ---------------------------------------------------------------------------
module rtc_bus_reader #(
   parameter int T_PH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] addr,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       a_d,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_bcd,
   output logic [6:0] rd_bin,
   output logic       bcd_err,
   output logic [3:0] dbg_state
);

   localparam int PW = (T_PH > 1) ? $clog2(T_PH) : 1;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      ADDR_SET = 4'd1,
      ADDR_WR  = 4'd2,
      ADDR_HLD = 4'd3,
      DATA_SET = 4'd4,
      DATA_RD  = 4'd5,
      DATA_HLD = 4'd6,
      CONV     = 4'd7,
      DONE     = 4'd8
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ph_q, ph_d;
   logic          ph_last;

   logic [7:0] ad_out_q, ad_out_d;
   logic       ad_oe_q, ad_oe_d;
   logic       a_d_q, a_d_d;
   logic       cs_n_q, cs_n_d;
   logic       rd_n_q, rd_n_d;
   logic       wr_n_q, wr_n_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] rd_bcd_q, rd_bcd_d;
   logic [6:0] rd_bin_q, rd_bin_d;
   logic       bcd_err_q, bcd_err_d;

   logic [3:0] nib_hi, nib_lo;
   logic       nib_bad;
   logic [6:0] bin_val;

   assign ph_last = (ph_q == PW'(T_PH - 1));

   // BCD to binary: hi*10 + lo, done in 7 bits (99 max for valid input).
   assign nib_hi  = rd_bcd_q[7:4];
   assign nib_lo  = rd_bcd_q[3:0];
   assign nib_bad = (nib_hi > 4'd9) || (nib_lo > 4'd9);
   assign bin_val = ({3'b000, nib_hi} * 7'd10) + {3'b000, nib_lo};

   // Next state and phase counter
   always_comb begin
      state_d = state_q;
      ph_d    = '0;
      case (state_q)
         IDLE: begin
            if (start) state_d = ADDR_SET;
         end
         ADDR_SET, ADDR_WR, ADDR_HLD, DATA_SET, DATA_RD, DATA_HLD: begin
            if (ph_last) begin
               ph_d = '0;
               case (state_q)
                  ADDR_SET: state_d = ADDR_WR;
                  ADDR_WR:  state_d = ADDR_HLD;
                  ADDR_HLD: state_d = DATA_SET;
                  DATA_SET: state_d = DATA_RD;
                  DATA_RD:  state_d = DATA_HLD;
                  default:  state_d = CONV;
               endcase
            end else begin
               ph_d = ph_q + PW'(1);
            end
         end
         CONV:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every pin comes straight
   // from a flop and changes on the same edge as the state itself.
   always_comb begin
      ad_oe_d   = 1'b0;
      a_d_d     = 1'b1;
      cs_n_d    = 1'b1;
      rd_n_d    = 1'b1;
      wr_n_d    = 1'b1;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      ad_out_d  = ad_out_q;
      rd_bcd_d  = rd_bcd_q;
      rd_bin_d  = rd_bin_q;
      bcd_err_d = bcd_err_q;

      case (state_d)
         IDLE:     busy_d = 1'b0;
         ADDR_SET: begin ad_oe_d = 1'b1; a_d_d = 1'b0; cs_n_d = 1'b0; end
         ADDR_WR:  begin ad_oe_d = 1'b1; a_d_d = 1'b0; cs_n_d = 1'b0; wr_n_d = 1'b0; end
         // Address stays driven past the strobe to give the RTC hold time.
         ADDR_HLD: begin ad_oe_d = 1'b1; a_d_d = 1'b0; end
         DATA_SET: cs_n_d = 1'b0;
         DATA_RD:  begin cs_n_d = 1'b0; rd_n_d = 1'b0; end
         DONE:     done_d = 1'b1;
         default:  ;
      endcase

      if (state_q == IDLE && start) ad_out_d = addr;

      // Sample read data at the very end of the read strobe.
      if (state_q == DATA_RD && ph_last) rd_bcd_d = ad_in;

      if (state_q == CONV) begin
         bcd_err_d = nib_bad;
         rd_bin_d  = nib_bad ? 7'd0 : bin_val;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ph_q      <= '0;
         ad_out_q  <= 8'h00;
         ad_oe_q   <= 1'b0;
         a_d_q     <= 1'b1;
         cs_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_bcd_q  <= 8'h00;
         rd_bin_q  <= 7'd0;
         bcd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         ad_out_q  <= ad_out_d;
         ad_oe_q   <= ad_oe_d;
         a_d_q     <= a_d_d;
         cs_n_q    <= cs_n_d;
         rd_n_q    <= rd_n_d;
         wr_n_q    <= wr_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_bcd_q  <= rd_bcd_d;
         rd_bin_q  <= rd_bin_d;
         bcd_err_q <= bcd_err_d;
      end
   end

   assign ad_out    = ad_out_q;
   assign ad_oe     = ad_oe_q;
   assign a_d       = a_d_q;
   assign cs_n      = cs_n_q;
   assign rd_n      = rd_n_q;
   assign wr_n      = wr_n_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_bcd    = rd_bcd_q;
   assign rd_bin    = rd_bin_q;
   assign bcd_err   = bcd_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_rtc_bus_reader.sv
// tb_rtc_bus_reader
// Two instances are exercised one at a time: dut0 with T_PH = 4 and dut1 with
// T_PH = 1. An RTC bus model answers reads from a memory, a reference model
// tracks each read by its cycle count since acceptance, and a compare process
// checks every output of both instances on every falling edge.
module tb_rtc_bus_reader;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start [2];
   logic [7:0] addr [2];
   logic [7:0] ad_in [2];
   logic [7:0] ad_out [2];
   logic       ad_oe [2], a_d [2], cs_n [2], rd_n [2], wr_n [2];
   logic       busy [2], done [2], bcd_err [2];
   logic [7:0] rd_bcd [2];
   logic [6:0] rd_bin [2];
   logic [3:0] dbg_state [2];

   int checks = 0;
   int errors = 0;

   logic [7:0] rtc_mem [256];
   logic [7:0] lat [2];

   // Reference model state: k = cycles since start acceptance, -1 when idle.
   int         k [2];
   logic [7:0] m_addr [2];
   logic [7:0] e_bcd [2];
   logic [6:0] e_bin [2];
   logic       e_err [2];

   // Expected {cs_n, wr_n, rd_n, ad_oe, a_d} for each of the six bus phases.
   logic [4:0] ph_tab [6];
   initial begin
      ph_tab[0] = 5'b01110;
      ph_tab[1] = 5'b00110;
      ph_tab[2] = 5'b11110;
      ph_tab[3] = 5'b01101;
      ph_tab[4] = 5'b01001;
      ph_tab[5] = 5'b11101;
   end

   always #5 clk = ~clk;

   rtc_bus_reader #(.T_PH(4)) dut0 (
      .clk(clk), .reset(reset), .start(start[0]), .addr(addr[0]), .ad_in(ad_in[0]),
      .ad_out(ad_out[0]), .ad_oe(ad_oe[0]), .a_d(a_d[0]), .cs_n(cs_n[0]),
      .rd_n(rd_n[0]), .wr_n(wr_n[0]), .busy(busy[0]), .done(done[0]),
      .rd_bcd(rd_bcd[0]), .rd_bin(rd_bin[0]), .bcd_err(bcd_err[0]),
      .dbg_state(dbg_state[0])
   );

   rtc_bus_reader #(.T_PH(1)) dut1 (
      .clk(clk), .reset(reset), .start(start[1]), .addr(addr[1]), .ad_in(ad_in[1]),
      .ad_out(ad_out[1]), .ad_oe(ad_oe[1]), .a_d(a_d[1]), .cs_n(cs_n[1]),
      .rd_n(rd_n[1]), .wr_n(wr_n[1]), .busy(busy[1]), .done(done[1]),
      .rd_bcd(rd_bcd[1]), .rd_bin(rd_bin[1]), .bcd_err(bcd_err[1]),
      .dbg_state(dbg_state[1])
   );

   function automatic int tph(input int g);
      return (g == 0) ? 4 : 1;
   endfunction

   // {err, bin} for a captured byte
   function automatic logic [7:0] bcd_model(input logic [7:0] b);
      int hi, lo;
      hi = int'(b) / 16;
      lo = int'(b) % 16;
      if (hi > 9 || lo > 9) return 8'h80;
      return {1'b0, 7'(hi * 10 + lo)};
   endfunction

   task automatic chk(input string name, input int g, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", name, g, act, exp, $time);
      end
   endtask

   // ---------------- RTC bus model ----------------
   // Latches the address while wr_n is low; returns memory data while rd_n is
   // low and random junk otherwise, so a mistimed capture shows up.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (wr_n[g] == 1'b0) lat[g] = ad_out[g];
         ad_in[g] = (rd_n[g] == 1'b0) ? rtc_mem[lat[g]] : 8'($urandom);
      end
   end

   // ---------------- reference model ----------------
   always @(posedge clk or posedge reset) begin
      for (int g = 0; g < 2; g++) begin
         if (reset) begin
            k[g] = -1; m_addr[g] = 8'h00;
            e_bcd[g] = 8'h00; e_bin[g] = 7'd0; e_err[g] = 1'b0;
         end else if (k[g] < 0) begin
            if (start[g] === 1'b1) begin
               k[g] = 0;
               m_addr[g] = addr[g];
            end
         end else begin
            k[g]++;
            if (k[g] > 6 * tph(g) + 1) k[g] = -1;
            else if (k[g] == 5 * tph(g)) e_bcd[g] = rtc_mem[m_addr[g]];
            else if (k[g] == 6 * tph(g) + 1) {e_err[g], e_bin[g]} = bcd_model(e_bcd[g]);
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!reset) begin
         for (int g = 0; g < 2; g++) begin
            int t;
            logic [6:0] eb;
            t = tph(g);
            if (k[g] < 0) eb = 7'b1110100;
            else if (k[g] < 6 * t) eb = {ph_tab[k[g] / t], 1'b1, 1'b0};
            else eb = {5'b11101, 1'b1, (k[g] == 6 * t + 1)};
            chk("bus", g, {25'd0, cs_n[g], wr_n[g], rd_n[g], ad_oe[g], a_d[g], busy[g], done[g]},
                {25'd0, eb});
            chk("result", g, {8'd0, ad_out[g], rd_bcd[g], bcd_err[g], rd_bin[g]},
                {8'd0, m_addr[g], e_bcd[g], e_err[g], e_bin[g]});
         end
      end
   end

   // ---------------- driver ----------------
   // mode 0: plain read; 1: extra start pulses in ADDR_WR and DONE;
   // 2: reset asserted in the middle of DATA_RD.
   task automatic do_read(input int g, input logic [7:0] a, input logic [7:0] d,
                          input int mode, input logic [7:0] x_bcd,
                          input logic [6:0] x_bin, input logic x_err);
      int t, n, c, ndone;
      bit got, rst_rel;
      t = tph(g);
      n = 0; ndone = 0; got = 0; rst_rel = 0;
      rtc_mem[a] = d;
      @(negedge clk);
      start[g] = 1'b1;
      addr[g]  = a;
      while (n < 200) begin
         @(negedge clk);
         n++;
         c = n - 1;
         start[g] = 1'b0;
         addr[g]  = 8'($urandom);
         if (rst_rel) begin
            #1 reset = 1'b0;
            rst_rel = 0;
         end
         if (mode == 1 && c == t) start[g] = 1'b1;
         if (mode == 1 && got && c == 6 * t + 2) chk("busy_after_done", g, 32'(busy[g]), 32'd0);
         if (mode == 2 && c == 4 * t + ((t > 1) ? 1 : 0)) begin
            #2 reset = 1'b1;
            #1;
            chk("abort_strobes", g, {29'd0, cs_n[g], rd_n[g], ad_oe[g]}, 32'b110);
            chk("abort_rd_bin", g, 32'(rd_bin[g]), 32'd0);
            rst_rel = 1;
         end
         if (done[g] === 1'b1) begin
            ndone++;
            if (!got) begin
               got = 1;
               chk("latency", g, 32'(c), 32'(6 * t + 1));
               chk("rd_bcd", g, 32'(rd_bcd[g]), 32'(x_bcd));
               chk("rd_bin", g, 32'(rd_bin[g]), 32'(x_bin));
               chk("bcd_err", g, 32'(bcd_err[g]), 32'(x_err));
               if (mode == 1) start[g] = 1'b1;
            end
         end
         if (c >= 6 * t + 3 && !rst_rel) break;
      end
      start[g] = 1'b0;
      if (mode == 2) chk("abort_no_done", g, 32'(ndone), 32'd0);
      else begin
         chk("done_seen", g, 32'(got), 32'd1);
         chk("done_count", g, 32'(ndone), 32'd1);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;
      for (int g = 0; g < 2; g++) begin
         start[g] = 1'b0; addr[g] = 8'h00; ad_in[g] = 8'h00; lat[g] = 8'h00;
      end
      #1 reset = 1'b1;
      #2;
      for (int g = 0; g < 2; g++) begin
         chk("reset_bus", g, {25'd0, cs_n[g], wr_n[g], rd_n[g], ad_oe[g], a_d[g], busy[g], done[g]},
             32'b1110100);
         chk("reset_result", g, {8'd0, ad_out[g], rd_bcd[g], bcd_err[g], rd_bin[g]}, 32'd0);
      end
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);

      // T_PH = 4
      do_read(0, 8'h22, 8'h47, 0, 8'h47, 7'd47, 1'b0);
      do_read(0, 8'h05, 8'h00, 0, 8'h00, 7'd0,  1'b0);
      do_read(0, 8'h06, 8'h99, 0, 8'h99, 7'd99, 1'b0);
      do_read(0, 8'h07, 8'h59, 0, 8'h59, 7'd59, 1'b0);
      do_read(0, 8'h08, 8'h3A, 0, 8'h3A, 7'd0,  1'b1);
      do_read(0, 8'h09, 8'h12, 0, 8'h12, 7'd12, 1'b0);
      do_read(0, 8'h0A, 8'h35, 1, 8'h35, 7'd35, 1'b0);
      do_read(0, 8'h0B, 8'h64, 2, 8'h00, 7'd0,  1'b0);
      do_read(0, 8'h0C, 8'h08, 0, 8'h08, 7'd8,  1'b0);

      // T_PH = 1
      do_read(1, 8'h22, 8'h47, 0, 8'h47, 7'd47, 1'b0);
      do_read(1, 8'h31, 8'h99, 0, 8'h99, 7'd99, 1'b0);
      do_read(1, 8'h32, 8'hF3, 0, 8'hF3, 7'd0,  1'b1);
      do_read(1, 8'h33, 8'h21, 1, 8'h21, 7'd21, 1'b0);
      do_read(1, 8'h34, 8'h11, 2, 8'h00, 7'd0,  1'b0);
      do_read(1, 8'h35, 8'h23, 0, 8'h23, 7'd23, 1'b0);

      // Randomized traffic: memory fixed per run, start pulses at random,
      // including while busy; the compare process checks every cycle.
      for (int i = 0; i < 256; i++)
         rtc_mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                      : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      for (int g = 0; g < 2; g++) begin
         for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            start[g] = ($urandom_range(0, 5) == 0);
            addr[g]  = 8'($urandom);
         end
         @(negedge clk);
         start[g] = 1'b0;
         repeat (30) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
